// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: forwarding,
// load-use and redirect handling, memory wait-state FSM with watchdog, perf counters.
module hazard_controller #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             ResultSrcE0,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             cnt_clr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              lw_stall;
  logic              mem_stall;

  // M stage wins over W since it holds the younger result
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       rw_m,
                                         input logic [4:0] rd_m,
                                         input logic       rw_w,
                                         input logic [4:0] rd_w);
    if (rw_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return 2'b10;
    end else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
  assign ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

  assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Memory stall freezes the whole pipe and masks flushes; PCSrcE persists in EX
  assign mem_stall = ((state_q == ST_RUN) && MemReqM && !MemReadyM)
                  || ((state_q == ST_WAIT) && !MemReadyM)
                  || (state_q == ST_ERR);

  assign StallF      = lw_stall | mem_stall;
  assign StallD      = lw_stall | mem_stall;
  assign StallE      = mem_stall;
  assign StallM      = mem_stall;
  assign FlushD      = PCSrcE & ~mem_stall;
  assign FlushE      = (lw_stall | PCSrcE) & ~mem_stall;
  assign mem_timeout = (state_q == ST_ERR);
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

  // Next-state logic for the memory wait FSM and the watchdog count
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (MemReqM && !MemReadyM) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      ST_WAIT: begin
        if (MemReadyM) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WC_W'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Saturating perf counters; clear takes priority
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (StallF && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (FlushD && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed plus randomized bench for hazard_controller against a behavioural
// model of the memory-wait watchdog, hazard rules and saturating counters.
module tb_hazard_controller;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 5;
  localparam int          MAXC    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM, cnt_clr;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, mem_timeout;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM), .cnt_clr(cnt_clr),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Model: an outstanding memory access that has seen m_waited unready cycles in a row
  bit m_timed_out;
  bit m_in_wait;
  int m_waited;
  int m_stall_cnt;
  int m_flush_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic zero_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE0 = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 0; cnt_clr = 0;
  endtask

  // Check every output against the model, then advance the model over one clock edge
  task automatic settle_check();
    bit lw, ms, outstanding, fd;
    #1;
    lw = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    outstanding = m_in_wait || MemReqM;
    ms = m_timed_out || (outstanding && !MemReadyM);
    fd = PCSrcE && !ms;
    chk("StallF", 32'(StallF), 32'(lw || ms));
    chk("StallD", 32'(StallD), 32'(lw || ms));
    chk("StallE", 32'(StallE), 32'(ms));
    chk("StallM", 32'(StallM), 32'(ms));
    chk("FlushD", 32'(FlushD), 32'(fd));
    chk("FlushE", 32'(FlushE), 32'((lw || PCSrcE) && !ms));
    chk("ForwardAE", 32'(ForwardAE), 32'(m_fwd(Rs1E)));
    chk("ForwardBE", 32'(ForwardBE), 32'(m_fwd(Rs2E)));
    chk("mem_timeout", 32'(mem_timeout), 32'(m_timed_out));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush_cnt));
    @(posedge clk);
    if (cnt_clr) begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if ((lw || ms) && m_stall_cnt < MAXC) m_stall_cnt++;
      if (fd && m_flush_cnt < MAXC) m_flush_cnt++;
    end
    if (!m_timed_out) begin
      if (outstanding && !MemReadyM) begin
        m_in_wait = 1;
        m_waited++;
        if (m_waited == TIMEOUT) m_timed_out = 1;
      end else if (MemReadyM) begin
        m_in_wait = 0;
        m_waited  = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    zero_inputs();
    reset = 1'b1;
    #1;
    chk("rst_mem_timeout", 32'(mem_timeout), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("rst_stalls", 32'({StallF, StallD, StallE, StallM}), 32'd0);
    chk("rst_flushes", 32'({FlushD, FlushE}), 32'd0);
    chk("rst_fwd", 32'({ForwardAE, ForwardBE}), 32'd0);
    m_timed_out = 0; m_in_wait = 0; m_waited = 0;
    m_stall_cnt = 0; m_flush_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int sc0;
    reset = 1'b1;
    zero_inputs();
    do_reset();

    // Forwarding priority and x0 suppression
    @(negedge clk);
    Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
    #1 chk("fwd_M", 32'(ForwardAE), 32'd2);
    settle_check();
    @(negedge clk);
    RegWriteM = 0;
    #1 chk("fwd_W", 32'(ForwardAE), 32'd1);
    settle_check();
    @(negedge clk);
    RdM = 0; RdW = 0; Rs1E = 0; RegWriteM = 1;
    #1 chk("fwd_x0", 32'(ForwardAE), 32'd0);
    settle_check();

    // Load-use
    @(negedge clk);
    zero_inputs();
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    #1 chk("lu_stall", 32'({StallF, StallD, FlushE, StallE}), 32'b1110);
    settle_check();
    @(negedge clk);
    RdE = 0; Rs2D = 0;
    #1 chk("lu_x0", 32'({StallF, FlushE}), 32'd0);
    settle_check();

    // Branch redirect
    @(negedge clk);
    zero_inputs();
    PCSrcE = 1;
    #1 chk("br_flush", 32'({FlushD, FlushE, StallF, StallE}), 32'b1100);
    sc0 = int'(flush_cnt);
    settle_check();
    @(negedge clk);
    PCSrcE = 0; cnt_clr = 1;
    #1 chk("br_flush_cnt", 32'(flush_cnt), 32'(sc0 + 1));
    settle_check();

    // Memory wait: three unready cycles then ready
    @(negedge clk);
    cnt_clr = 0; MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1 chk("mw_stall", 32'({StallF, StallD, StallE, StallM}), 32'hF);
      settle_check();
    end
    @(negedge clk);
    MemReadyM = 1;
    #1 chk("mw_release", 32'({StallF, StallD, StallE, StallM}), 32'd0);
    settle_check();
    @(negedge clk);
    MemReqM = 0; MemReadyM = 0;
    #1 chk("mw_stall_cnt", 32'(stall_cnt), 32'd3);
    settle_check();

    // Redirect held off during a memory stall, applied on release
    @(negedge clk);
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    #1 chk("bms_noflush", 32'({FlushD, FlushE}), 32'd0);
    settle_check();
    @(negedge clk);
    #1 chk("bms_noflush2", 32'({FlushD, FlushE}), 32'd0);
    settle_check();
    @(negedge clk);
    MemReadyM = 1;
    #1 chk("bms_flush", 32'({FlushD, FlushE}), 32'b11);
    settle_check();

    // Watchdog timeout, stickiness and counter saturation
    @(negedge clk);
    zero_inputs();
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (i > 0) @(negedge clk);
      #1 chk("to_pre", 32'(mem_timeout), 32'd0);
      settle_check();
    end
    @(negedge clk);
    #1 chk("to_set", 32'(mem_timeout), 32'd1);
    settle_check();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      MemReadyM = 1; PCSrcE = 1'(i & 1);
      settle_check();
    end
    @(negedge clk);
    #1 chk("to_sticky", 32'({mem_timeout, StallM, FlushD}), 32'b110);
    chk("stall_sat", 32'(stall_cnt), 32'(MAXC));
    settle_check();
    do_reset();
    @(negedge clk);
    #1 chk("to_cleared", 32'({mem_timeout, StallF}), 32'd0);
    settle_check();

    // Randomized traffic against the model
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
        Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
        RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
        RdW  = 5'($urandom_range(0, 3));
        ResultSrcE0 = 1'($urandom_range(0, 1));
        RegWriteM   = 1'($urandom_range(0, 1));
        RegWriteW   = 1'($urandom_range(0, 1));
        PCSrcE      = ($urandom_range(0, 3) == 0);
        MemReqM     = ($urandom_range(0, 4) < 2);
        MemReadyM   = ($urandom_range(0, 9) < (blk < 3 ? 6 : 3));
        cnt_clr     = ($urandom_range(0, 29) == 0);
        settle_check();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central hazard and sequencing controller for the 5-stage RV32I pipeline. Drives the stall, flush and forwarding controls for the IF/ID, ID/EX and EX/MEM stages.
- Handles three hazard types: load-use hazards, branch/jump redirects, and variable-latency data-memory wait states (req/ready handshake), with a timeout watchdog.
- Keeps saturating stall/flush performance counters.

Parameters:
- TIMEOUT, 16, max consecutive memory-wait cycles before error (>=2).
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- Rs1D  in  5  decode source reg 1
- Rs2D  in  5  decode source reg 2
- Rs1E  in  5  execute source reg 1
- Rs2E  in  5  execute source reg 2
- RdE  in  5  execute dest reg
- RdM  in  5  memory-stage dest reg
- RdW  in  5  writeback dest reg
- ResultSrcE0  in  1  EX instruction is a load
- RegWriteM  in  1  M-stage writes a register
- RegWriteW  in  1  W-stage writes a register
- PCSrcE  in  1  branch taken or jump resolved in EX
- MemReqM  in  1  M-stage load/store request to data memory
- MemReadyM  in  1  data memory completes request this cycle
- cnt_clr  in  1  synchronous clear of perf counters
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID
- StallE  out  1  hold ID/EX
- StallM  out  1  hold EX/MEM
- FlushD  out  1  clear IF/ID
- FlushE  out  1  clear ID/EX
- ForwardAE  out  2  ALU operand A select
- ForwardBE  out  2  ALU operand B select
- mem_timeout  out  1  sticky watchdog error
- stall_cnt  out  CNT_W  cycles with StallF=1
- flush_cnt  out  CNT_W  cycles with FlushD=1

Behaviour:
- Forwarding (combinational, independent of FSM). ForwardAE:
  - 2'b10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 2'b01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 2'b00.
  - M has priority over W. ForwardBE is identical using Rs2E.
- lwStall = ResultSrcE0 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- memStall = (state==RUN && MemReqM && !MemReadyM) || (state==WAIT && !MemReadyM) || state==ERR.
- Control outputs (combinational from state and inputs):
  - StallF = StallD = lwStall | memStall.
  - StallE = StallM = memStall.
  - FlushD = PCSrcE & !memStall.
  - FlushE = (lwStall | PCSrcE) & !memStall.
  - A memory stall freezes the whole pipe and suppresses every flush. The redirect is applied on the first non-stalled cycle, because EX is held and PCSrcE persists.
- FSM states: RUN, WAIT, ERR. State and wait_cnt are registered.
  - RUN: if MemReqM && !MemReadyM, go to WAIT with wait_cnt<=1; else stay.
  - WAIT: if MemReadyM, go to RUN with wait_cnt<=0 (pipe releases the same cycle ready is seen). Else if wait_cnt==TIMEOUT-1, go to ERR. Else wait_cnt<=wait_cnt+1.
  - ERR: absorbing. All stalls are held at 1, flushes at 0, mem_timeout=1. Only reset exits.
- Counters:
  - stall_cnt increments on every clk with StallF=1; flush_cnt increments on every clk with FlushD=1.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment and clears to 0.
- Reset (async) values: state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_timeout=0.
  - With zeroed inputs, all stall/flush outputs are 0 and ForwardAE/BE=00.
- Reset mid-WAIT or in ERR returns immediately to RUN with all outputs deasserted.

Test Plan:
- Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Then RegWriteM=0 -> ForwardAE=01. Then RdM=RdW=0 with Rs1E=0 -> 00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=1, FlushE=1, StallE=0 for one cycle. RdE=0 with Rs2D=0 -> no stall.
- Branch: PCSrcE=1 with no memory request -> FlushD=FlushE=1, stalls 0, flush_cnt +1.
- Memory wait: MemReqM=1, MemReadyM low for 3 cycles then high -> StallF/D/E/M=1 for 3 cycles, 0 on the ready cycle, stall_cnt=3.
- Branch during memory stall: PCSrcE=1 while MemReadyM=0 -> FlushD=FlushE=0. When MemReadyM=1 -> FlushD=FlushE=1 that cycle.
- Timeout: TIMEOUT=4, MemReqM=1, MemReadyM=0 held -> ERR entered after the cycle with wait_cnt=3, mem_timeout=1 sticky even after MemReadyM=1. Async reset -> mem_timeout=0, state RUN.
